inoc_rr_arbiter: RTL and testbench
==================================

Name: inoc_rr_arbiter

Overview:
- Packet-locked round-robin arbiter that shares one downstream valid/ready buffer (the iDMA/iNoC FIFO input) between NUM_REQ upstream requesters.
- Grants one requester at a time and holds the grant until that requester's last beat is accepted downstream.
- Tags every output beat with the source index.
- Priority rotates so that no requester starves.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 32, payload width per beat.
- IDX_W, $clog2(NUM_REQ), width of source index (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. Synchronous, active-low: sampled only on the rising edge of clk.
- req_valid_in  input  NUM_REQ  per-requester beat valid.
- req_data_in  input  NUM_REQ*DATA_W  requester i payload in bits [i*DATA_W +: DATA_W].
- req_last_in  input  NUM_REQ  per-requester last-beat-of-packet flag.
- req_ready_out  output  NUM_REQ  per-requester ready.
- out_valid  output  1  beat valid to downstream FIFO.
- out_data  output  DATA_W  payload of granted requester.
- out_last  output  1  last flag of granted requester.
- out_src_id  output  IDX_W  index of granted requester.
- out_ready_in  input  1  downstream ready (FIFO not full).
- busy  output  1  1 while a packet grant is held.

Behaviour:
- State machine: ARB and LOCK. Registers: state, grant_idx[IDX_W], rr_ptr[IDX_W].
- Reset (rst_n=0 at posedge): state=ARB, grant_idx=0, rr_ptr=0.
  - Outputs while in reset/ARB: out_valid=0, req_ready_out=0, busy=0, out_last=0.
  - out_src_id=grant_idx and out_data=selected payload; both are don't-care while out_valid=0.
- ARB:
  - Combinationally search req_valid_in starting at index rr_ptr, ascending with wrap mod NUM_REQ. The first set bit wins.
  - If any valid: at the next edge, grant_idx<=winner and state<=LOCK.
  - If none valid: stay in ARB.
  - No beat is transferred in ARB; arbitration costs exactly 1 cycle per packet.
- LOCK:
  - out_valid = req_valid_in[grant_idx].
  - out_data, out_last = granted requester's data and last.
  - out_src_id = grant_idx. busy=1.
  - req_ready_out = one-hot at grant_idx, equal to out_ready_in; all other bits 0.
  - Transfer occurs when out_valid && out_ready_in.
  - Transfer with out_last=1: state<=ARB and rr_ptr<=(grant_idx+1) mod NUM_REQ. When NUM_REQ is not a power of 2, wrap explicitly to 0 when grant_idx=NUM_REQ-1.
  - Transfer with out_last=0: stay in LOCK.
  - Granted valid deasserted mid-packet: stay in LOCK with out_valid=0. The grant is not released, and other requesters' valids are ignored.
- Single-beat packet (last=1 on first beat): ARB 1 cycle, LOCK 1 cycle, back to ARB. Sustained throughput is 1 beat per 2 cycles.
- Back-pressure: out_ready_in=0 holds the beat; out_data/out_last must remain driven from the requester.
- Requesters must keep valid and data stable until ready (standard valid/ready). The arbiter does not register payload; the data path is combinational mux only.
- Simultaneous requests: a requester asserting valid while another holds the lock waits. Fairness is guaranteed: with all NUM_REQ requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
- rr_ptr updates only on packet completion, never in ARB without a transfer.
- Reset mid-packet: the next edge with rst_n=0 returns to ARB with rr_ptr=0; the partial packet is abandoned. Upstream/downstream reset together; no recovery is provided.
- No combinational path from out_ready_in to out_valid. The only such path is out_ready_in to req_ready_out.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with all req_valid_in=4'b1111 -> out_valid=0, req_ready_out=0, busy=0. After release, the first grant is requester 0 (out_src_id=0) after one ARB cycle.
- Packet lock: req0 sends 3 beats (0xA0,0xA1,0xA2 with last on 0xA2) while req2 is valid throughout -> out_data shows A0,A1,A2 with out_src_id=0 and req_ready_out[2]=0 throughout. Then 1 ARB cycle, then req2 is granted (out_src_id=2).
- Round-robin fairness: all 4 valid, single-beat packets, out_ready_in=1 for 16 cycles -> grant sequence 0,1,2,3,0,1,2,3, one transfer every 2 cycles, 8 transfers.
- Back-pressure: during req1 beat 0x55 set out_ready_in=0 for 4 cycles -> out_valid=1, out_data=0x55 stable, req_ready_out=4'b0000. Transfer completes on the cycle out_ready_in returns to 1.
- Mid-packet bubble: req3 drops valid after beat 1 of a 3-beat packet for 2 cycles while req0 is valid -> state stays LOCK, out_valid=0, and req0 is not granted until req3's last beat transfers.
- Reset mid-packet: assert rst_n=0 during beat 2 of a req2 packet -> next cycle state=ARB, busy=0, rr_ptr=0. With req0 and req2 valid after release, req0 is granted first.

Source files
------------

// File: rtl/inoc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// inoc_rr_arbiter
// Packet-locked round-robin arbiter. NUM_REQ valid/ready requesters share one
// downstream valid/ready port. A requester is granted for a whole packet, and
// the grant is held until its last beat is accepted. Every output beat is
// tagged with the source index. The priority pointer moves one past the
// requester that has just finished, so no requester can starve.
//
// The data path is a pure combinational mux. Payload is never registered.
// The only combinational path from out_ready_in goes to req_ready_out.
// -----------------------------------------------------------------------------
module inoc_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]        req_last_in,
  output logic [NUM_REQ-1:0]        req_ready_out,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [IDX_W-1:0]          out_src_id,
  input  logic                      out_ready_in,
  output logic                      busy
);

  typedef enum logic {
    ARB  = 1'b0,   // searching for the next requester; no beat moves
    LOCK = 1'b1    // grant held until the granted packet's last beat leaves
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] grant_idx, grant_next;
  logic [IDX_W-1:0] rr_ptr, rr_next;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] cand;
  int               sum;
  logic             any_valid;
  logic             grant_valid;
  logic             grant_last;
  logic [DATA_W-1:0] grant_data;
  logic             xfer;

  // Signals of the currently granted requester, selected by grant_idx.
  assign grant_valid = req_valid_in[grant_idx];
  assign grant_last  = req_last_in[grant_idx];
  assign grant_data  = req_data_in[int'(grant_idx)*DATA_W +: DATA_W];

  // A beat moves only while the lock is held and both sides handshake.
  assign xfer = (state == LOCK) && grant_valid && out_ready_in;

  // Pointer advance after a completed packet. The wrap is explicit so that a
  // NUM_REQ that is not a power of two never yields an out-of-range index.
  assign ptr_inc = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Rotating priority search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    // NOTE: every variable written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    any_valid = 1'b0;
    winner    = '0;
    sum       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!any_valid && req_valid_in[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // State register plus the grant and priority pointer (synchronous reset).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers here are read in the same cycle, so ordering must not matter.
    if (!rst_n) begin
      state     <= ARB;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_next;
      grant_idx <= grant_next;
      rr_ptr    <= rr_next;
    end
  end

  // Next-state logic: take a grant in ARB, release it on the last accepted beat.
  always_comb begin
    state_next = state;
    grant_next = grant_idx;
    rr_next    = rr_ptr;
    case (state)
      ARB: begin
        if (any_valid) begin
          grant_next = winner;
          state_next = LOCK;
        end
      end
      LOCK: begin
        // A mid-packet valid drop simply leaves xfer low, so the lock is kept.
        if (xfer && grant_last) begin
          state_next = ARB;
          rr_next    = ptr_inc;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Output logic: the granted requester is connected straight through while locked.
  always_comb begin
    out_valid     = 1'b0;
    out_last      = 1'b0;
    busy          = 1'b0;
    req_ready_out = '0;
    out_data      = grant_data;
    out_src_id    = grant_idx;
    if (state == LOCK) begin
      out_valid                = grant_valid;
      out_last                 = grant_last;
      busy                     = 1'b1;
      req_ready_out[grant_idx] = out_ready_in;
    end
  end

endmodule

// File: tb/tb_inoc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inoc_rr_arbiter
// Directed and randomised stimulus for inoc_rr_arbiter. The reference model is
// an abstract one: per-requester beat queues, a "locked to owner" flag and a
// priority index. It predicts every output on every cycle. The directed steps
// also compare the log of accepted beats with fixed expected sequences.
// -----------------------------------------------------------------------------
module tb_inoc_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ*DATA_W-1:0] req_data_in;
  logic [NUM_REQ-1:0]        req_last_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [IDX_W-1:0]          out_src_id;
  logic                      out_ready_in;
  logic                      busy;

  inoc_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_in (req_valid_in),
    .req_data_in  (req_data_in),
    .req_last_in  (req_last_in),
    .req_ready_out(req_ready_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_src_id   (out_src_id),
    .out_ready_in (out_ready_in),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pending beats per requester, each stored as {last, data}.
  logic [DATA_W:0]   q [NUM_REQ][$];
  bit [NUM_REQ-1:0]  hold;
  // Abstract arbiter model.
  bit                m_lock;
  int                m_owner;
  int                m_ptr;
  // Log of accepted beats.
  int                log_src [$];
  logic [DATA_W-1:0] log_data [$];
  int                pushed, popped;
  int                checks, errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [DATA_W-1:0] d, input bit l);
    q[r].push_back({l, d});
    pushed++;
  endtask

  function automatic int pick(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic void clear_log();
    log_src.delete();
    log_data.delete();
  endfunction

  // One clock cycle. Drive the requesters from their queues, check every
  // output against the model, then step the model across the rising edge.
  task automatic cyc();
    logic [DATA_W:0]    b;
    logic [NUM_REQ-1:0] exp_rdy;
    bit                 exp_valid;
    int                 w;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q[i].size() != 0) begin
        b = q[i][0];
        req_valid_in[i]                  = !hold[i];
        req_data_in[i*DATA_W +: DATA_W]  = b[DATA_W-1:0];
        req_last_in[i]                   = b[DATA_W];
      end else begin
        req_valid_in[i]                  = 1'b0;
        req_data_in[i*DATA_W +: DATA_W]  = '0;
        req_last_in[i]                   = 1'b0;
      end
    end
    #1;
    exp_valid = m_lock && req_valid_in[m_owner];
    exp_rdy   = '0;
    if (m_lock && out_ready_in) exp_rdy[m_owner] = 1'b1;
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("req_ready_out", 64'(req_ready_out), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(m_lock));
    check("out_last", 64'(out_last), 64'(m_lock && req_last_in[m_owner]));
    if (m_lock) check("out_src_id", 64'(out_src_id), 64'(m_owner));
    if (exp_valid) check("out_data", 64'(out_data), 64'(req_data_in[m_owner*DATA_W +: DATA_W]));
    @(posedge clk);
    if (!rst_n) begin
      m_lock = 1'b0; m_owner = 0; m_ptr = 0;
    end else if (!m_lock) begin
      w = pick(m_ptr, req_valid_in);
      if (w >= 0) begin
        m_lock  = 1'b1;
        m_owner = w;
      end
    end else if (req_valid_in[m_owner] && out_ready_in) begin
      b = q[m_owner].pop_front();
      log_src.push_back(m_owner);
      log_data.push_back(b[DATA_W-1:0]);
      popped++;
      if (b[DATA_W]) begin
        m_lock = 1'b0;
        m_ptr  = (m_owner + 1) % NUM_REQ;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    int budget;
    checks = 0; errors = 0; pushed = 0; popped = 0;
    m_lock = 1'b0; m_owner = 0; m_ptr = 0;
    hold = '0;
    rst_n = 1'b0;
    out_ready_in = 1'b1;
    req_valid_in = '0;
    req_data_in  = '0;
    req_last_in  = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset with every requester valid, then the first grant after release.
    for (int i = 0; i < NUM_REQ; i++) push(i, DATA_W'(32'h100 + i), 1'b1);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("first_grant_src", 64'(out_src_id), 64'd0);
    check("first_grant_busy", 64'(busy), 64'd1);
    repeat (7) cyc();
    check("init_log_size", 64'(log_src.size()), 64'd4);
    for (int k = 0; k < 4; k++) check("init_order", 64'(log_src[k]), 64'(k));
    clear_log();

    // Fairness: all requesters continuously valid with single-beat packets.
    for (int i = 0; i < NUM_REQ; i++) begin
      push(i, DATA_W'(32'h10 + i), 1'b1);
      push(i, DATA_W'(32'h20 + i), 1'b1);
    end
    repeat (16) cyc();
    check("rr_count", 64'(log_src.size()), 64'd8);
    for (int k = 0; k < 8; k++) check("rr_order", 64'(log_src[k]), 64'(k % 4));
    clear_log();

    // Packet lock: req0 sends three beats while req2 waits.
    push(0, 32'hA0, 1'b0); push(0, 32'hA1, 1'b0); push(0, 32'hA2, 1'b1);
    push(2, 32'hB0, 1'b1);
    repeat (6) cyc();
    check("lock_count", 64'(log_src.size()), 64'd4);
    check("lock_b0", 64'({log_src[0], log_data[0]}), 64'({32'd0, 32'hA0}));
    check("lock_b1", 64'({log_src[1], log_data[1]}), 64'({32'd0, 32'hA1}));
    check("lock_b2", 64'({log_src[2], log_data[2]}), 64'({32'd0, 32'hA2}));
    check("lock_next", 64'({log_src[3], log_data[3]}), 64'({32'd2, 32'hB0}));
    clear_log();

    // Back-pressure on a single req1 beat.
    push(1, 32'h55, 1'b1);
    out_ready_in = 1'b0;
    cyc();
    repeat (4) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h55);
      check("bp_ready", 64'(req_ready_out), 64'd0);
      check("bp_src", 64'(out_src_id), 64'd1);
      cyc();
    end
    check("bp_held", 64'(log_src.size()), 64'd0);
    out_ready_in = 1'b1;
    cyc();
    check("bp_done", 64'(log_src.size()), 64'd1);
    check("bp_done_data", 64'(log_data[0]), 64'h55);
    clear_log();

    // Mid-packet bubble: req3 stalls for two cycles while req0 waits.
    push(3, 32'hC0, 1'b0); push(3, 32'hC1, 1'b0); push(3, 32'hC2, 1'b1);
    push(0, 32'hD0, 1'b1);
    cyc(); cyc(); cyc();
    hold[3] = 1'b1;
    repeat (2) begin
      cyc();
      check("bubble_busy", 64'(busy), 64'd1);
      check("bubble_valid", 64'(out_valid), 64'd0);
      check("bubble_src", 64'(out_src_id), 64'd3);
    end
    hold[3] = 1'b0;
    cyc(); cyc(); cyc();
    check("bubble_count", 64'(log_src.size()), 64'd4);
    check("bubble_c2", 64'({log_src[2], log_data[2]}), 64'({32'd3, 32'hC2}));
    check("bubble_d0", 64'({log_src[3], log_data[3]}), 64'({32'd0, 32'hD0}));
    clear_log();

    // Reset mid-packet: the req2 packet is abandoned and the pointer returns to 0.
    push(2, 32'hE0, 1'b0); push(2, 32'hE1, 1'b0); push(2, 32'hE2, 1'b1);
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    pushed = 0; popped = 0;
    clear_log();
    rst_n = 1'b1;
    push(0, 32'hF0, 1'b1);
    push(2, 32'hF2, 1'b1);
    cyc();
    check("rst_regrant_src", 64'(out_src_id), 64'd0);
    check("rst_regrant_busy", 64'(busy), 64'd1);
    repeat (3) cyc();
    check("rst_log_count", 64'(log_src.size()), 64'd2);
    check("rst_log_first", 64'({log_src[0], log_data[0]}), 64'({32'd0, 32'hF0}));
    check("rst_log_second", 64'({log_src[1], log_data[1]}), 64'({32'd2, 32'hF2}));
    clear_log();

    // Randomised traffic: random packets, back-pressure and upstream bubbles.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          n = $urandom_range(1, 3);
          for (int b = 0; b < n; b++) push(i, DATA_W'($urandom), (b == n - 1));
        end
        hold[i] = ($urandom_range(0, 7) == 0);
      end
      out_ready_in = ($urandom_range(0, 3) != 0);
      cyc();
    end
    hold = '0;
    out_ready_in = 1'b1;
    budget = 0;
    while (popped != pushed && budget < 300) begin
      cyc();
      budget++;
    end
    check("random_drain", 64'(popped), 64'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
